// File: rtl/jtag_tap_responder.sv
// JTAG TAP responder for simulation benches.
// The master's TCK/TMS/TDI/TRSTn pins are oversampled on the system clock, and
// the IEEE 1149.1 TAP state machine runs on the detected TCK edges. The target
// provides IDCODE, BYPASS and a 32-bit USER scratch register, and drives TDO
// back to the master.
module jtag_tap_responder #(
  parameter int                  IR_WIDTH    = 5,
  parameter logic [31:0]         IDCODE_VAL  = 32'h1234_5679,
  parameter logic [IR_WIDTH-1:0] INSN_IDCODE = 5'h01,
  parameter logic [IR_WIDTH-1:0] INSN_USER   = 5'h10,
  parameter logic [IR_WIDTH-1:0] INSN_BYPASS = 5'h1F
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                jtag_TCK,
  input  logic                jtag_TMS,
  input  logic                jtag_TDI,
  input  logic                jtag_TRSTn,
  output logic                jtag_TDO_data,
  output logic                jtag_TDO_driven,
  output logic [3:0]          tap_state,
  output logic [IR_WIDTH-1:0] ir_value,
  output logic [31:0]         user_reg,
  output logic                user_update
);

  typedef enum logic [3:0] {
    TLR      = 4'd0,
    RTI      = 4'd1,
    SEL_DR   = 4'd2,
    CAP_DR   = 4'd3,
    SH_DR    = 4'd4,
    EX1_DR   = 4'd5,
    PAUSE_DR = 4'd6,
    EX2_DR   = 4'd7,
    UPD_DR   = 4'd8,
    SEL_IR   = 4'd9,
    CAP_IR   = 4'd10,
    SH_IR    = 4'd11,
    EX1_IR   = 4'd12,
    PAUSE_IR = 4'd13,
    EX2_IR   = 4'd14,
    UPD_IR   = 4'd15
  } tap_state_e;

  // The data register chosen at Capture-DR; it fixes the shift length
  // until the next capture.
  typedef enum logic [1:0] {
    DR_BYPASS = 2'd0,
    DR_IDCODE = 2'd1,
    DR_USER   = 2'd2
  } dr_sel_e;

  tap_state_e          state;
  tap_state_e          state_next;
  dr_sel_e             dr_sel;
  logic [IR_WIDTH-1:0] ir_shift;
  logic [31:0]         dr_shift;

  logic tck_s1, tck_s2, tck_prev;
  logic tms_s1, tms_s2;
  logic tdi_s1, tdi_s2;
  logic trst_s1, trst_s2;
  logic tck_rise, tck_fall;
  logic in_ir_path;

  assign tap_state = state;
  assign tck_rise  = tck_s2 & ~tck_prev;
  assign tck_fall  = ~tck_s2 & tck_prev;

  // Two-flop synchronizers for the master pins, plus the previous synced TCK.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tck_s1   <= 1'b0;
      tck_s2   <= 1'b0;
      tck_prev <= 1'b0;
      tms_s1   <= 1'b0;
      tms_s2   <= 1'b0;
      tdi_s1   <= 1'b0;
      tdi_s2   <= 1'b0;
      trst_s1  <= 1'b1;
      trst_s2  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop here read the value
      // from before this edge, which is what gives a true two-stage chain.
      tck_s1   <= jtag_TCK;
      tck_s2   <= tck_s1;
      tck_prev <= tck_s2;
      tms_s1   <= jtag_TMS;
      tms_s2   <= tms_s1;
      tdi_s1   <= jtag_TDI;
      tdi_s2   <= tdi_s1;
      trst_s1  <= jtag_TRSTn;
      trst_s2  <= trst_s1;
    end
  end

  // Standard 1149.1 next-state function, driven by the synced TMS.
  always_comb begin
    // NOTE: a default assignment on entry keeps this block free of latches
    // even if a case arm is added later without an assignment.
    state_next = state;
    unique case (state)
      TLR:      state_next = tms_s2 ? TLR      : RTI;
      RTI:      state_next = tms_s2 ? SEL_DR   : RTI;
      SEL_DR:   state_next = tms_s2 ? SEL_IR   : CAP_DR;
      CAP_DR:   state_next = tms_s2 ? EX1_DR   : SH_DR;
      SH_DR:    state_next = tms_s2 ? EX1_DR   : SH_DR;
      EX1_DR:   state_next = tms_s2 ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: state_next = tms_s2 ? EX2_DR   : PAUSE_DR;
      EX2_DR:   state_next = tms_s2 ? UPD_DR   : SH_DR;
      UPD_DR:   state_next = tms_s2 ? SEL_DR   : RTI;
      SEL_IR:   state_next = tms_s2 ? TLR      : CAP_IR;
      CAP_IR:   state_next = tms_s2 ? EX1_IR   : SH_IR;
      SH_IR:    state_next = tms_s2 ? EX1_IR   : SH_IR;
      EX1_IR:   state_next = tms_s2 ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: state_next = tms_s2 ? EX2_IR   : PAUSE_IR;
      EX2_IR:   state_next = tms_s2 ? UPD_IR   : SH_IR;
      UPD_IR:   state_next = tms_s2 ? SEL_DR   : RTI;
      default:  state_next = TLR;
    endcase
  end

  // TDO comes from the IR chain while in the IR column, else from the DR chain.
  always_comb begin
    in_ir_path = 1'b0;
    if (state inside {CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR})
      in_ir_path = 1'b1;
  end

  // TAP state machine, shift registers and registered TDO/update outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= TLR;
      dr_sel          <= DR_BYPASS;
      ir_value        <= INSN_IDCODE;
      ir_shift        <= '0;
      dr_shift        <= '0;
      user_reg        <= '0;
      user_update     <= 1'b0;
      jtag_TDO_data   <= 1'b0;
      jtag_TDO_driven <= 1'b0;
    end else begin
      user_update <= 1'b0;
      if (!trst_s2) begin
        // Test reset wins over any TCK edge; USER and shift data are kept.
        state           <= TLR;
        ir_value        <= INSN_IDCODE;
        jtag_TDO_driven <= 1'b0;
      end else begin
        if (tck_rise) begin
          state <= state_next;
          unique case (state)
            CAP_IR: ir_shift <= {{(IR_WIDTH-1){1'b0}}, 1'b1};
            SH_IR:  ir_shift <= {tdi_s2, ir_shift[IR_WIDTH-1:1]};
            CAP_DR: begin
              if (ir_value == INSN_IDCODE) begin
                dr_sel   <= DR_IDCODE;
                dr_shift <= IDCODE_VAL;
              end else if (ir_value == INSN_USER) begin
                dr_sel   <= DR_USER;
                dr_shift <= user_reg;
              end else begin
                dr_sel   <= DR_BYPASS;
                dr_shift <= '0;
              end
            end
            SH_DR: begin
              if (dr_sel == DR_BYPASS) dr_shift[0] <= tdi_s2;
              else                     dr_shift    <= {tdi_s2, dr_shift[31:1]};
            end
            default: ;
          endcase
        end
        if (tck_fall) begin
          jtag_TDO_data   <= in_ir_path ? ir_shift[0] : dr_shift[0];
          jtag_TDO_driven <= (state == SH_IR) || (state == SH_DR);
          unique case (state)
            UPD_IR: ir_value <= ir_shift;
            UPD_DR: begin
              if (ir_value == INSN_USER) begin
                user_reg    <= dr_shift;
                user_update <= 1'b1;
              end
            end
            TLR:     ir_value <= INSN_IDCODE;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Directed bench for jtag_tap_responder: bit-bangs the JTAG pins slowly
// relative to the system clock and checks states, registers and TDO streams.
module tb_jtag_tap_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn;
  logic        jtag_TDO_data, jtag_TDO_driven;
  logic [3:0]  tap_state;
  logic [4:0]  ir_value;
  logic [31:0] user_reg;
  logic        user_update;

  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;

  logic [31:0] tdo_word;
  logic        drv_all;
  int          upd_base;

  jtag_tap_responder dut (
    .clock           (clock),
    .reset           (reset),
    .jtag_TCK        (jtag_TCK),
    .jtag_TMS        (jtag_TMS),
    .jtag_TDI        (jtag_TDI),
    .jtag_TRSTn      (jtag_TRSTn),
    .jtag_TDO_data   (jtag_TDO_data),
    .jtag_TDO_driven (jtag_TDO_driven),
    .tap_state       (tap_state),
    .ir_value        (ir_value),
    .user_reg        (user_reg),
    .user_update     (user_update)
  );

  always #5 clock = ~clock;

  // Count clocks during which user_update is high.
  always @(negedge clock) if (user_update === 1'b1) upd_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full TCK period: TMS/TDI set up, rise, high 4 clocks, fall, low 4 clocks.
  task automatic tck_pulse(input logic tms, input logic tdi);
    jtag_TMS = tms;
    jtag_TDI = tdi;
    repeat (2) @(negedge clock);
    jtag_TCK = 1'b1;
    repeat (4) @(negedge clock);
    jtag_TCK = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  // Shift n bits LSB-first; TMS=1 on the last bit. TDO is read before each rise.
  task automatic scan(input int n, input logic [31:0] din,
                      output logic [31:0] dout, output logic drv);
    dout = '0;
    drv  = 1'b1;
    for (int i = 0; i < n; i++) begin
      dout[i] = jtag_TDO_data;
      drv     = drv & jtag_TDO_driven;
      tck_pulse(i == n - 1, din[i]);
    end
  endtask

  // From RTI: load an instruction and return to RTI.
  task automatic load_ir(input logic [4:0] op);
    logic [31:0] d;
    logic        dv;
    tck_pulse(1'b1, 1'b0);
    tck_pulse(1'b1, 1'b0);
    tck_pulse(1'b0, 1'b0);
    tck_pulse(1'b0, 1'b0);
    scan(5, {27'd0, op}, d, dv);
    tck_pulse(1'b1, 1'b0);
    tck_pulse(1'b0, 1'b0);
  endtask

  // From RTI: go to Shift-DR.
  task automatic goto_shdr();
    tck_pulse(1'b1, 1'b0);
    tck_pulse(1'b0, 1'b0);
    tck_pulse(1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    jtag_TCK = 1'b0; jtag_TMS = 1'b1; jtag_TDI = 1'b0; jtag_TRSTn = 1'b1;
    repeat (3) @(negedge clock);

    // Reset values
    check("rst_state", {28'd0, tap_state}, 32'd0);
    check("rst_ir", {27'd0, ir_value}, 32'h01);
    check("rst_user", user_reg, 32'd0);
    check("rst_upd", {31'd0, user_update}, 32'd0);
    check("rst_tdo", {31'd0, jtag_TDO_data}, 32'd0);
    check("rst_drv", {31'd0, jtag_TDO_driven}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // Five TMS=1 rises keep/put the TAP in TLR
    for (int i = 0; i < 5; i++) tck_pulse(1'b1, 1'b0);
    check("tlr_5tms", {28'd0, tap_state}, 32'd0);

    // IDCODE scan
    tck_pulse(1'b0, 1'b0);
    check("rti", {28'd0, tap_state}, 32'd1);
    check("rti_drv", {31'd0, jtag_TDO_driven}, 32'd0);
    tck_pulse(1'b1, 1'b0);
    check("sel_dr", {28'd0, tap_state}, 32'd2);
    tck_pulse(1'b0, 1'b0);
    check("cap_dr", {28'd0, tap_state}, 32'd3);
    tck_pulse(1'b0, 1'b0);
    check("sh_dr", {28'd0, tap_state}, 32'd4);
    scan(32, 32'd0, tdo_word, drv_all);
    check("idcode_tdo", tdo_word, 32'h1234_5679);
    check("idcode_drv", {31'd0, drv_all}, 32'd1);
    check("ex1dr", {28'd0, tap_state}, 32'd5);
    check("ex1dr_drv", {31'd0, jtag_TDO_driven}, 32'd0);
    tck_pulse(1'b1, 1'b0);
    check("upd_dr", {28'd0, tap_state}, 32'd8);
    tck_pulse(1'b0, 1'b0);

    // IR capture pattern and load of 0x1F
    tck_pulse(1'b1, 1'b0);
    tck_pulse(1'b1, 1'b0);
    check("sel_ir", {28'd0, tap_state}, 32'd9);
    tck_pulse(1'b0, 1'b0);
    tck_pulse(1'b0, 1'b0);
    check("sh_ir", {28'd0, tap_state}, 32'd11);
    scan(5, 32'h1F, tdo_word, drv_all);
    check("ir_cap_tdo", tdo_word, 32'h01);
    check("ir_drv", {31'd0, drv_all}, 32'd1);
    check("ir_held", {27'd0, ir_value}, 32'h01);
    tck_pulse(1'b1, 1'b0);
    check("upd_ir", {28'd0, tap_state}, 32'd15);
    check("ir_1f", {27'd0, ir_value}, 32'h1F);
    tck_pulse(1'b0, 1'b0);

    // BYPASS: 0xA5 comes back one TCK late behind the captured 0
    goto_shdr();
    scan(9, 32'h0A5, tdo_word, drv_all);
    check("bypass_tdo", tdo_word, 32'h14A);
    tck_pulse(1'b1, 1'b0);
    tck_pulse(1'b0, 1'b0);

    // USER write
    load_ir(5'h10);
    check("ir_user", {27'd0, ir_value}, 32'h10);
    goto_shdr();
    scan(32, 32'hCAFE_F00D, tdo_word, drv_all);
    check("user_old", tdo_word, 32'd0);
    upd_base = upd_cnt;
    tck_pulse(1'b1, 1'b0);
    check("user_wr", user_reg, 32'hCAFE_F00D);
    check("user_pulse", upd_cnt - upd_base, 32'd1);
    tck_pulse(1'b0, 1'b0);

    // USER read-back (writing the same value back)
    goto_shdr();
    scan(32, 32'hCAFE_F00D, tdo_word, drv_all);
    check("user_rd", tdo_word, 32'hCAFE_F00D);
    tck_pulse(1'b1, 1'b0);
    tck_pulse(1'b0, 1'b0);
    check("user_keep", user_reg, 32'hCAFE_F00D);

    // TRSTn mid-ShDR with USER selected
    goto_shdr();
    for (int i = 0; i < 4; i++) tck_pulse(1'b0, 1'b1);
    check("pre_trst", {28'd0, tap_state}, 32'd4);
    upd_base = upd_cnt;
    jtag_TRSTn = 1'b0;
    repeat (3) @(negedge clock);
    check("trst_state", {28'd0, tap_state}, 32'd0);
    check("trst_ir", {27'd0, ir_value}, 32'h01);
    jtag_TCK = 1'b1;
    repeat (4) @(negedge clock);
    jtag_TCK = 1'b0;
    repeat (4) @(negedge clock);
    check("trst_hold", {28'd0, tap_state}, 32'd0);
    check("trst_user", user_reg, 32'hCAFE_F00D);
    check("trst_noupd", upd_cnt - upd_base, 32'd0);
    jtag_TRSTn = 1'b1;
    repeat (4) @(negedge clock);

    // Unknown opcode 0x07 acts as bypass; 5 TMS=1 from ShDR reaches TLR
    tck_pulse(1'b0, 1'b0);
    load_ir(5'h07);
    check("ir_07", {27'd0, ir_value}, 32'h07);
    goto_shdr();
    tdo_word = '0;
    tdo_word[0] = jtag_TDO_data; tck_pulse(1'b0, 1'b1);
    tdo_word[1] = jtag_TDO_data; tck_pulse(1'b0, 1'b1);
    tdo_word[2] = jtag_TDO_data; tck_pulse(1'b0, 1'b0);
    tdo_word[3] = jtag_TDO_data;
    check("unk_bypass", tdo_word, 32'h6);
    upd_base = upd_cnt;
    for (int i = 0; i < 5; i++) tck_pulse(1'b1, 1'b0);
    check("unk_tlr", {28'd0, tap_state}, 32'd0);
    check("unk_ir", {27'd0, ir_value}, 32'h01);
    check("unk_noupd", upd_cnt - upd_base, 32'd0);
    check("unk_user", user_reg, 32'hCAFE_F00D);

    // Reset asserted mid-shift
    tck_pulse(1'b0, 1'b0);
    load_ir(5'h10);
    goto_shdr();
    tck_pulse(1'b0, 1'b1);
    tck_pulse(1'b0, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_state", {28'd0, tap_state}, 32'd0);
    check("mid_rst_ir", {27'd0, ir_value}, 32'h01);
    check("mid_rst_user", user_reg, 32'd0);
    check("mid_rst_drv", {31'd0, jtag_TDO_driven}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time bound so the run can never hang.
  initial begin
    #5ms;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
